// File: rtl/fact_pkg.sv
// fact_pkg: register offsets, N limit and FSM state codes for the factorial responder
package fact_pkg;
  localparam logic [1:0] REG_N      = 2'd0;
  localparam logic [1:0] REG_GO     = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;
  localparam logic [3:0] N_MAX      = 4'd12;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;
endpackage

// File: rtl/fact_core.sv
// fact_core: iterative n! engine, one multiply per cycle, GO ignored while running
module fact_core
  import fact_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [3:0]  n,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] result
);
  state_t      state_q, state_d;
  logic [31:0] prod_q, prod_d, result_q, result_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d, err_q, err_d, start, bad;
  assign start = go && state_q != RUN;
  assign bad   = n > N_MAX;
  always_comb begin
    state_d  = state_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = done_q;
    err_d    = err_q;
    if (start) begin
      state_d  = bad ? DONE : RUN;
      done_d   = bad;
      err_d    = bad;
      prod_d   = 32'd1;
      cnt_d    = n;
      result_d = bad ? 32'd0 : result_q;
    end else if (state_q == RUN) begin
      state_d  = cnt_q > 4'd1 ? RUN : DONE;
      prod_d   = cnt_q > 4'd1 ? prod_q * {28'd0, cnt_q} : prod_q;
      cnt_d    = cnt_q > 4'd1 ? cnt_q - 4'd1 : cnt_q;
      result_d = cnt_q > 4'd1 ? result_q : prod_q;
      done_d   = cnt_q <= 4'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
  assign busy   = state_q == RUN;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
endmodule

// File: rtl/fact_responder.sv
// fact_responder: memory-mapped factorial accelerator; FACT_IRQ_EN adds a done-level irq port
module fact_responder
  import fact_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h0000_0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd
`ifdef FACT_IRQ_EN
  ,
  output logic        irq
`endif
);
  logic        sel, wr, go, busy, done, err, irq_bit, unused;
  logic [3:0]  n_q, n_d;
  logic [31:0] result;
  assign sel    = a[31:4] == BASE[31:4];
  assign wr     = sel && we;
  assign go     = wr && a[3:2] == REG_GO && wd[0];
  assign n_d    = wr && a[3:2] == REG_N ? wd[3:0] : n_q;
  assign unused = ^{a[1:0], wd[31:4]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) n_q <= '0;
    else     n_q <= n_d;
  end
  fact_core u_core (
    .clk    (clk),
    .rst    (rst),
    .go     (go),
    .n      (n_q),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result)
  );
  // done is itself a register set entering DONE and cleared by an accepted GO, so it is the irq level
`ifdef FACT_IRQ_EN
  assign irq     = done;
  assign irq_bit = done;
`else
  assign irq_bit = 1'b0;
`endif
  always_comb
    rd = !sel                 ? 32'd0 :
         a[3:2] == REG_N      ? {28'd0, n_q} :
         a[3:2] == REG_GO     ? {31'd0, busy} :
         a[3:2] == REG_STATUS ? {29'd0, irq_bit, err, done} :
                                result;
endmodule

// File: tb/tb_fact_responder.sv
// tb_fact_responder: randomized self-checking bench against a plain-arithmetic factorial model
module tb_fact_responder;
  localparam logic [31:0] BASE = 32'h0000_0800;
  logic        clk = 1'b0, rst = 1'b1, we = 1'b0;
  logic [31:0] a = '0, wd = '0, rd;
  int checks = 0, errors = 0;
`ifdef FACT_IRQ_EN
  logic irq;
`endif

  fact_responder #(.BASE(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .a   (a),
    .wd  (wd),
    .rd  (rd)
`ifdef FACT_IRQ_EN
    ,
    .irq (irq)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fact(input int n);
    longint r = 1;
    for (int i = 2; i <= n; i++) r *= i;
    return r[31:0];
  endfunction

  function automatic logic [31:0] exp_status(input bit e);
`ifdef FACT_IRQ_EN
    return {29'd0, 1'b1, e, 1'b1};
`else
    return {29'd0, 1'b0, e, 1'b1};
`endif
  endfunction

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    we = 1'b1; a = addr; wd = data;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rdreg(input logic [31:0] addr, output logic [31:0] data);
    a = addr;
    #1 data = rd;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc, input int start_cnt, input bit noise);
    logic [31:0] s, b;
    int c = start_cnt;
    s = '0;
    for (int g = 0; g < 40; g++) begin
      rdreg(BASE + 32'h8, s);
      if (s[0]) break;
      rdreg(BASE + 32'h4, b);
      checks++;
      if (b !== 32'd1) begin errors++; $display("FAIL %s busy: got %0d want 1 at cycle %0d", tag, b, c); end
      if (noise && $urandom_range(0, 2) == 0) wr(BASE + 32'h4, $urandom);
      else @(negedge clk);
      c++;
    end
    checks++;
    if (!s[0] || c != exp_cyc) begin
      errors++; $display("FAIL %s latency: got %0d cycles (done=%0b) want %0d", tag, c, s[0], exp_cyc);
    end
  endtask

  task automatic run_n(input string tag, input logic [3:0] n, input bit noise);
    logic [31:0] r, s, nr;
    bit e = n > 4'd12;
    wr(BASE, {$urandom} & 32'hFFFF_FFF0 | {28'd0, n});
    wr(BASE + 32'h4, 32'd1);
    wait_done(tag, e ? 0 : (n > 0 ? int'(n) : 1), 0, noise);
    rdreg(BASE + 32'hC, r);
    rdreg(BASE + 32'h8, s);
    rdreg(BASE, nr);
    checks += 3;
    if (r !== (e ? 32'd0 : fact(n))) begin errors++; $display("FAIL %s result n=%0d: got %0d want %0d", tag, n, r, e ? 0 : fact(n)); end
    if (s !== exp_status(e)) begin errors++; $display("FAIL %s status n=%0d: got %h want %h", tag, n, s, exp_status(e)); end
    if (nr !== {28'd0, n}) begin errors++; $display("FAIL %s nread: got %h want %h", tag, nr, n); end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rdreg(BASE + 32'(i * 4), v);
      checks++;
      if (v !== 32'd0) begin errors++; $display("FAIL reset reg%0d: got %h want 0", i, v); end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_n("n5", 4'd5, 1'b0);
  endtask

  task automatic test_edges();
    run_n("n0", 4'd0, 1'b0);
    run_n("n1", 4'd1, 1'b0);
    run_n("n12", 4'd12, 1'b0);
    run_n("n13", 4'd13, 1'b0);
    run_n("n15", 4'd15, 1'b0);
  endtask

  task automatic test_go_in_run();
    logic [31:0] r, nr;
    wr(BASE, 32'd6);
    wr(BASE + 32'h4, 32'd1);
    @(negedge clk);
    wr(BASE + 32'h4, 32'd1);
    wr(BASE, 32'd9);
    wait_done("gorun", 6, 3, 1'b0);
    rdreg(BASE + 32'hC, r);
    rdreg(BASE, nr);
    checks += 2;
    if (r !== 32'd720) begin errors++; $display("FAIL gorun result: got %0d want 720", r); end
    if (nr !== 32'd9) begin errors++; $display("FAIL gorun nwrite: got %0d want 9", nr); end
    wr(BASE + 32'h4, 32'd0);
    rdreg(BASE + 32'h4, r);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL go0 busy: got %0d want 0", r); end
  endtask

  task automatic test_unselected();
    logic [31:0] v;
    wr(BASE + 32'h10, 32'd3);
    wr(BASE + 32'h14, 32'd1);
    wr(BASE + 32'hC, 32'h1234);
    wr(BASE + 32'h8, 32'h0);
    rdreg(BASE + 32'h10, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL unsel rd: got %h want 0", v); end
    rdreg(BASE, v);
    checks++;
    if (v !== 32'd9) begin errors++; $display("FAIL unsel n: got %0d want 9", v); end
    rdreg(BASE + 32'hC, v);
    checks++;
    if (v !== 32'd720) begin errors++; $display("FAIL ro result: got %0d want 720", v); end
    rdreg(BASE + 32'h8, v);
    checks++;
    if (v !== exp_status(1'b0)) begin errors++; $display("FAIL ro status: got %h want %h", v, exp_status(1'b0)); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] v;
    wr(BASE, 32'd10);
    wr(BASE + 32'h4, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rdreg(BASE + 32'(i * 4), v);
      checks++;
      if (v !== 32'd0) begin errors++; $display("FAIL midrst reg%0d: got %h want 0", i, v); end
    end
    @(negedge clk);
    rst = 1'b0;
    wr(BASE + 32'h4, 32'd1);
    wait_done("postrst", 1, 0, 1'b0);
    rdreg(BASE + 32'hC, v);
    checks++;
    if (v !== 32'd1) begin errors++; $display("FAIL postrst result: got %0d want 1", v); end
    run_n("n3", 4'd3, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) run_n("rand", 4'($urandom_range(0, 15)), 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) run_n("b2b", 4'($urandom_range(2, 12)), 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_go_in_run();
    test_unselected();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
